// File: rtl/spi_master_scheduler.sv
// Round-robin scheduler sharing one SPI mode-0 master port (8-bit frames, MSB first) among NUM_REQ requesters.
// Define SPI_GAP_EN to hold SS high for GAP_CYCLES extra cycles between frames.
module spi_master_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*8-1:0]   tx_data_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [7:0]             rx_data_o,
    output logic                   busy_o,
    output logic                   sck_o,
    output logic                   mosi_o,
    output logic                   ss_o,
    input  logic                   miso_i
);

    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
`ifdef SPI_GAP_EN
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
`endif

    // state    | meaning
    // S_IDLE   | arbitrate among pending requests
    // S_SETUP  | SS low, first MOSI bit presented, SCK low
    // S_SCK_HI | SCK high; MISO sampled on entry
    // S_SCK_LO | SCK low; next MOSI bit shifted out on entry
    // S_HOLD   | SS still low after the last falling SCK edge
    // S_DONE   | SS high, ack pulse, received byte published
    // S_GAP    | optional SS-high spacing before the next arbitration
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SCK_HI, S_SCK_LO, S_HOLD, S_DONE, S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        div_q, div_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [7:0]           tx_sh_q, tx_sh_d;
    logic [7:0]           rx_sh_q, rx_sh_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic                 ss_q, ss_d;

    logic                 win_found;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        ptr_next;
    logic [7:0]           tx_sel;
    logic                 div_last;

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PW'(sum);
    endfunction

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_i[rr_index(ptr_q, i)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(ptr_q, i);
            end
        end
    end

    assign ptr_next = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign tx_sel   = tx_data_i[{win_idx, 3'b000} +: 8];
    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        ptr_d     = ptr_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        busy_d    = busy_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        ss_d      = ss_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d          = S_SETUP;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    busy_d           = 1'b1;
                    ptr_d            = ptr_next;
                    tx_sh_d          = tx_sel;
                    div_d            = '0;
                    bit_cnt_d        = '0;
                    ss_d             = 1'b0;
                    sck_d            = 1'b0;
                    mosi_d           = tx_sel[7];
                end
            end
            S_SETUP, S_SCK_LO: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    state_d   = S_SCK_HI;
                    div_d     = '0;
                    sck_d     = 1'b1;
                    rx_sh_d   = {rx_sh_q[6:0], miso_i};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_SCK_HI: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    div_d = '0;
                    sck_d = 1'b0;
                    // bit_cnt wraps back to 0 once the eighth bit has been sampled
                    if (bit_cnt_q == 3'd0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_SCK_LO;
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        mosi_d  = tx_sh_q[6];
                    end
                end
            end
            S_HOLD: begin
                div_d = div_q + 1'b1;
                if (div_last) begin
                    state_d   = S_DONE;
                    div_d     = '0;
                    ss_d      = 1'b1;
                    rx_data_d = rx_sh_q;
                    ack_d     = gnt_q;
                end
            end
            S_DONE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                div_d  = '0;
`ifdef SPI_GAP_EN
                state_d = S_GAP;
`else
                state_d = S_IDLE;
`endif
            end
`ifdef SPI_GAP_EN
            S_GAP: begin
                div_d = div_q + 1'b1;
                if (div_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            ptr_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign ack_o     = ack_q;
    assign rx_data_o = rx_data_q;
    assign busy_o    = busy_q;
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;
    assign ss_o      = ss_q;

endmodule

// File: tb/tb_spi_master_scheduler.sv
// Bench for spi_master_scheduler: oversampling mode-0 slave model plus round-robin reference model.
module tb_spi_master_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int FRAME_LAT  = 17 * CLK_DIV + 1;
`ifdef SPI_GAP_EN
    localparam int SS_GAP = GAP_CYCLES + 2;
`else
    localparam int SS_GAP = 2;
`endif
    localparam int TIMEOUT = 400;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic [NUM_REQ-1:0]   req_i;
    logic [NUM_REQ*8-1:0] tx_data_i;
    logic [NUM_REQ-1:0]   gnt_o;
    logic [NUM_REQ-1:0]   ack_o;
    logic [7:0]           rx_data_o;
    logic                 busy_o;
    logic                 sck_o;
    logic                 mosi_o;
    logic                 ss_o;
    logic                 miso_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    spi_master_scheduler #(
        .NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .tx_data_i(tx_data_i),
        .gnt_o(gnt_o), .ack_o(ack_o), .rx_data_o(rx_data_o), .busy_o(busy_o),
        .sck_o(sck_o), .mosi_o(mosi_o), .ss_o(ss_o), .miso_i(miso_i)
    );

    // Slave replies with a byte chosen by frame index since reset (0xAA first).
    function automatic logic [7:0] slave_byte(input int n);
        return (n == 0) ? 8'hAA : 8'(8'h5A + n * 8'h37);
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int k);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    logic       sl_sck_q, sl_ss_q;
    logic [7:0] sl_tx, sl_rx;
    int         sl_bits, sl_frames;
    logic [7:0] sl_rx_q[$];

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sl_sck_q  <= 1'b0;
            sl_ss_q   <= 1'b1;
            sl_tx     <= '0;
            sl_rx     <= '0;
            sl_bits   <= 0;
            sl_frames <= 0;
            miso_i    <= 1'b0;
            sl_rx_q.delete();
        end else begin
            sl_sck_q <= sck_o;
            sl_ss_q  <= ss_o;
            if (sl_ss_q && !ss_o) begin
                sl_tx     <= slave_byte(sl_frames);
                miso_i    <= (slave_byte(sl_frames) >= 8'h80);
                sl_frames <= sl_frames + 1;
                sl_bits   <= 0;
            end else if (!ss_o && !sl_sck_q && sck_o) begin
                sl_rx   <= {sl_rx[6:0], mosi_o};
                sl_bits <= sl_bits + 1;
            end else if (!ss_o && sl_sck_q && !sck_o) begin
                sl_tx  <= {sl_tx[6:0], 1'b0};
                miso_i <= sl_tx[6];
            end else if (!sl_ss_q && ss_o) begin
                if (sl_bits == 8) sl_rx_q.push_back(sl_rx);
                sl_bits <= 0;
            end
        end
    end

    int sck_rises = 0;
    int sck_bad   = 0;
    always @(posedge sck_o) begin
        sck_rises <= sck_rises + 1;
        if (ss_o) sck_bad <= sck_bad + 1;
    end

    task automatic do_reset();
        reset_i   = 1'b1;
        req_i     = '0;
        tx_data_i = '0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic wait_ack(output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk_i);
            cycles++;
            if (ack_o != '0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; req_i = '0; tx_data_i = '0;
        @(negedge clk_i);
        checks++; if (ss_o !== 1'b1)   begin errors++; $display("FAIL reset_ss got %b want 1", ss_o); end
        checks++; if (sck_o !== 1'b0)  begin errors++; $display("FAIL reset_sck got %b want 0", sck_o); end
        checks++; if (mosi_o !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi_o); end
        checks++; if (gnt_o !== '0)    begin errors++; $display("FAIL reset_gnt got %b want 0", gnt_o); end
        checks++; if (ack_o !== '0)    begin errors++; $display("FAIL reset_ack got %b want 0", ack_o); end
        checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_rx got %h want 00", rx_data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    endtask

    task automatic test_single_frame();
        int cyc; bit to; int s0;
        do_reset();
        s0 = sck_rises;
        tx_data_i[7:0] = 8'h3C;
        req_i = 4'b0001;
        wait_ack(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout no ack in %0d cycles", TIMEOUT); end
        checks++; if (cyc != FRAME_LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", cyc, FRAME_LAT); end
        checks++; if (ack_o !== 4'b0001) begin errors++; $display("FAIL single_ack got %b want 0001", ack_o); end
        checks++; if (rx_data_o !== 8'hAA) begin errors++; $display("FAIL single_rx got %h want aa", rx_data_o); end
        checks++; if (ss_o !== 1'b1) begin errors++; $display("FAIL single_ss_in_ack got %b want 1", ss_o); end
        checks++; if (sck_rises - s0 != 8) begin errors++; $display("FAIL single_sck_rises got %0d want 8", sck_rises - s0); end
        req_i = '0;
        @(negedge clk_i);
        checks++; if (gnt_o !== '0 || busy_o !== 1'b0 || ack_o !== '0)
            begin errors++; $display("FAIL single_release got gnt=%b busy=%b ack=%b want 0/0/0", gnt_o, busy_o, ack_o); end
        repeat (4) @(negedge clk_i);
        checks++; if (sl_rx_q.size() != 1) begin errors++; $display("FAIL single_slave_count got %0d want 1", sl_rx_q.size()); end
        else begin
            checks++; if (sl_rx_q[0] !== 8'h3C) begin errors++; $display("FAIL single_slave_data got %h want 3c", sl_rx_q[0]); end
        end
        checks++; if (sck_bad != 0) begin errors++; $display("FAIL sck_with_ss_high got %0d want 0", sck_bad); end
    endtask

    task automatic test_round_robin();
        int cyc; bit to;
        int order[5] = '{0, 1, 2, 3, 0};
        logic [7:0] bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] exp_sl[$];
        do_reset();
        tx_data_i = {8'h44, 8'h33, 8'h22, 8'h11};
        req_i = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_ack(cyc, to);
            checks++; if (to) begin errors++; $display("FAIL rr_timeout frame %0d", f); end
            checks++; if (ack_o !== onehot(order[f])) begin errors++; $display("FAIL rr_ack frame %0d got %b want %b", f, ack_o, onehot(order[f])); end
            checks++; if (gnt_o !== onehot(order[f])) begin errors++; $display("FAIL rr_gnt frame %0d got %b want %b", f, gnt_o, onehot(order[f])); end
            checks++; if (rx_data_o !== slave_byte(f)) begin errors++; $display("FAIL rr_rx frame %0d got %h want %h", f, rx_data_o, slave_byte(f)); end
            exp_sl.push_back(bytes[order[f]]);
        end
        req_i = '0;
        repeat (4) @(negedge clk_i);
        checks++;
        if (sl_rx_q.size() != exp_sl.size()) begin errors++; $display("FAIL rr_slave_count got %0d want %0d", sl_rx_q.size(), exp_sl.size()); end
        else for (int i = 0; i < exp_sl.size(); i++) begin
            checks++;
            if (sl_rx_q[i] !== exp_sl[i]) begin errors++; $display("FAIL rr_slave_data idx %0d got %h want %h", i, sl_rx_q[i], exp_sl[i]); end
        end
    endtask

    task automatic test_pointer_wrap();
        int cyc; bit to;
        do_reset();
        tx_data_i = {8'(32'($urandom)), 16'h0000, 8'(32'($urandom))};
        req_i = 4'b1000;
        wait_ack(cyc, to);
        checks++; if (to || ack_o !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b want 1000", ack_o); end
        req_i = 4'b1001;
        wait_ack(cyc, to);
        checks++; if (to || ack_o !== 4'b0001) begin errors++; $display("FAIL wrap_second got %b want 0001", ack_o); end
        req_i = 4'b1000;
        wait_ack(cyc, to);
        checks++; if (to || ack_o !== 4'b1000) begin errors++; $display("FAIL wrap_third got %b want 1000", ack_o); end
        req_i = '0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_late_request();
        int cyc; bit to; bit seen;
        do_reset();
        tx_data_i = {8'h00, 8'(32'($urandom)), 8'(32'($urandom)), 8'h00};
        req_i = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT && !seen; i++) begin
            @(negedge clk_i);
            seen = (sck_o === 1'b1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL late_no_sck got 0 want 1"); end
        req_i[2] = 1'b1;
        to = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk_i);
            checks++;
            if (gnt_o !== 4'b0010) begin errors++; $display("FAIL late_gnt_hold got %b want 0010", gnt_o); end
            if (ack_o != '0) begin to = 1'b0; break; end
        end
        checks++; if (to || ack_o !== 4'b0010) begin errors++; $display("FAIL late_ack1 got %b want 0010", ack_o); end
        req_i[1] = 1'b0;
        cyc = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk_i);
            cyc++;
            if (gnt_o != '0) break;
        end
        checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL late_gnt2 got %b want 0100", gnt_o); end
        checks++; if (cyc != SS_GAP) begin errors++; $display("FAIL late_grant_delay got %0d want %0d", cyc, SS_GAP); end
        wait_ack(cyc, to);
        checks++; if (to || ack_o !== 4'b0100) begin errors++; $display("FAIL late_ack2 got %b want 0100", ack_o); end
        req_i = '0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_reset_mid_frame();
        int cyc; bit to; int s0; bit acked;
        do_reset();
        tx_data_i = {16'h0000, 8'(32'($urandom)), 8'(32'($urandom))};
        req_i = 4'b0001;
        wait_ack(cyc, to);
        req_i = 4'b0010;
        s0 = sck_rises;
        for (int i = 0; i < TIMEOUT && (sck_rises - s0) < 3; i++) @(negedge clk_i);
        checks++; if (sck_rises - s0 != 3) begin errors++; $display("FAIL midrst_sck_rises got %0d want 3", sck_rises - s0); end
        #2 reset_i = 1'b1;
        #1;
        checks++; if (ss_o !== 1'b1 || sck_o !== 1'b0) begin errors++; $display("FAIL midrst_spi got ss=%b sck=%b want 1/0", ss_o, sck_o); end
        checks++; if (gnt_o !== '0 || busy_o !== 1'b0) begin errors++; $display("FAIL midrst_gnt got gnt=%b busy=%b want 0/0", gnt_o, busy_o); end
        checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL midrst_rx got %h want 00", rx_data_o); end
        req_i = '0;
        acked = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            if (ack_o != '0) acked = 1'b1;
        end
        reset_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            if (ack_o != '0) acked = 1'b1;
        end
        checks++; if (acked) begin errors++; $display("FAIL midrst_ack got 1 want 0"); end
        tx_data_i[7:0] = 8'hA5;
        req_i = 4'b0001;
        wait_ack(cyc, to);
        checks++; if (to || cyc != FRAME_LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", cyc, FRAME_LAT); end
        checks++; if (ack_o !== 4'b0001 || rx_data_o !== 8'hAA) begin errors++; $display("FAIL midrst_frame got ack=%b rx=%h want 0001/aa", ack_o, rx_data_o); end
        req_i = '0;
        repeat (4) @(negedge clk_i);
        checks++; if (sl_rx_q.size() != 1) begin errors++; $display("FAIL midrst_slave_count got %0d want 1", sl_rx_q.size()); end
        else begin
            checks++; if (sl_rx_q[0] !== 8'hA5) begin errors++; $display("FAIL midrst_slave_data got %h want a5", sl_rx_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit to; int ss_high;
        do_reset();
        tx_data_i = {16'h0000, 8'(32'($urandom)), 8'(32'($urandom))};
        req_i = 4'b0011;
        wait_ack(cyc, to);
        checks++; if (to || ack_o !== 4'b0001) begin errors++; $display("FAIL b2b_ack1 got %b want 0001", ack_o); end
        ss_high = 0;
        for (int i = 0; i < TIMEOUT && ss_o === 1'b1; i++) begin
            ss_high++;
            @(negedge clk_i);
        end
        checks++; if (ss_high != SS_GAP) begin errors++; $display("FAIL b2b_ss_gap got %0d want %0d", ss_high, SS_GAP); end
        wait_ack(cyc, to);
        checks++; if (to || ack_o !== 4'b0010) begin errors++; $display("FAIL b2b_ack2 got %b want 0010", ack_o); end
        req_i = '0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_random();
        int cyc; bit to; int ptr; int exp; int exp_lat; bit drop; bit acked;
        logic [7:0] exp_sl[$];
        do_reset();
        ptr = 0;
        for (int k = 0; k < NUM_REQ; k++) tx_data_i[8*k +: 8] = 8'(32'($urandom));
        req_i = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        for (int f = 0; f < 25; f++) begin
            exp     = rr_pick(req_i, ptr);
            exp_lat = (f == 0) ? FRAME_LAT : FRAME_LAT - 1 + SS_GAP;
            drop    = ($urandom_range(0, 3) == 0);
            exp_sl.push_back(tx_data_i[8*exp +: 8]);
            cyc = 0;
            acked = 1'b0;
            for (int i = 0; i < TIMEOUT; i++) begin
                @(negedge clk_i);
                cyc++;
                if (drop && cyc == 20) req_i[exp] = 1'b0;
                if (ack_o != '0) begin acked = 1'b1; break; end
            end
            checks++; if (!acked) begin errors++; $display("FAIL rand_timeout frame %0d", f); end
            checks++; if (ack_o !== onehot(exp)) begin errors++; $display("FAIL rand_owner frame %0d got %b want %b", f, ack_o, onehot(exp)); end
            checks++; if (rx_data_o !== slave_byte(f)) begin errors++; $display("FAIL rand_rx frame %0d got %h want %h", f, rx_data_o, slave_byte(f)); end
            checks++; if (cyc != exp_lat) begin errors++; $display("FAIL rand_latency frame %0d got %0d want %0d", f, cyc, exp_lat); end
            ptr = (exp + 1) % NUM_REQ;
            if ($urandom_range(0, 1) == 0) req_i[exp] = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!req_i[k] && $urandom_range(0, 2) == 0) begin
                    req_i[k] = 1'b1;
                    tx_data_i[8*k +: 8] = 8'(32'($urandom));
                end
            end
            if (f == 24) req_i = '0;
            else if (req_i == '0) req_i[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
        end
        repeat (4) @(negedge clk_i);
        checks++;
        if (sl_rx_q.size() != exp_sl.size()) begin errors++; $display("FAIL rand_slave_count got %0d want %0d", sl_rx_q.size(), exp_sl.size()); end
        else for (int i = 0; i < exp_sl.size(); i++) begin
            checks++;
            if (sl_rx_q[i] !== exp_sl[i]) begin errors++; $display("FAIL rand_slave_data idx %0d got %h want %h", i, sl_rx_q[i], exp_sl[i]); end
        end
        checks++; if (sck_bad != 0) begin errors++; $display("FAIL rand_sck_with_ss_high got %0d want 0", sck_bad); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_i   = 1'b1;
        req_i     = '0;
        tx_data_i = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_pointer_wrap();
        test_late_request();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
